// File: rtl/weight_loader.sv
// Packs a kernel/bias word stream into weight memory at the read-side addresses.
// Optional bias phase: define WEIGHT_LOADER_BIAS_EN.
module weight_loader #(
  parameter int N_UNITS = 16,
  parameter int DATA_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [15:0]        i_start_addr,
  input  logic [7:0]         i_kernel_size,
  input  logic [N_UNITS-1:0] i_active_units,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [DATA_W-1:0]  i_in_data,
  output logic               o_mem_we,
  output logic [15:0]        o_mem_addr,
  output logic [DATA_W-1:0]  o_mem_wdata,
  output logic               o_busy,
  output logic               o_done
);

  typedef enum logic [1:0] {
    IDLE, LOAD_W, LOAD_B, FIN
  } state_t;

  function automatic logic [7:0] popcnt(
    input logic [N_UNITS-1:0] m
  );
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < N_UNITS; i++)
      c = c + 8'(m[i]);
    return c;
  endfunction

  state_t              r_state;
  logic                r_in_ready;
  logic                r_busy;
  logic                r_done;
  logic                r_we;
  logic [15:0]         r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [15:0]         r_ptr;
  logic [15:0]         r_wleft;

  logic [7:0]          w_cnt;
  logic [15:0]         w_total;
  logic                w_xfer;

  assign w_cnt   = popcnt(i_active_units);
  assign w_total = 16'(w_cnt) * 16'(i_kernel_size);
  assign w_xfer  = i_in_valid & r_in_ready;

`ifdef WEIGHT_LOADER_BIAS_EN
  localparam int IW = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;

  logic [N_UNITS-1:0]  r_rem;
  logic [15:0]         r_bias_base;
  logic [N_UNITS-1:0]  w_rem_nx;
  logic [IW-1:0]       w_idx;

  // Lowest remaining set bit is the next physical unit to receive a bias.
  always_comb begin
    w_idx = '0;
    for (int i = N_UNITS - 1; i >= 0; i--)
      if (r_rem[i]) w_idx = IW'(i);
  end

  assign w_rem_nx = r_rem & (r_rem - 1'b1);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_ptr      <= '0;
      r_wleft    <= '0;
`ifdef WEIGHT_LOADER_BIAS_EN
      r_rem       <= '0;
      r_bias_base <= '0;
`endif
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (i_start) begin
            r_ptr   <= i_start_addr;
            r_wleft <= w_total;
            r_busy  <= 1'b1;
`ifdef WEIGHT_LOADER_BIAS_EN
            r_rem       <= i_active_units;
            r_bias_base <= i_start_addr + w_total;
            if (w_total != 16'd0) begin
              r_state    <= LOAD_W;
              r_in_ready <= 1'b1;
            end else if (w_cnt != 8'd0) begin
              r_state    <= LOAD_B;
              r_in_ready <= 1'b1;
            end else begin
              r_state <= FIN;
              r_done  <= 1'b1;
            end
`else
            if (w_total != 16'd0) begin
              r_state    <= LOAD_W;
              r_in_ready <= 1'b1;
            end else begin
              r_state <= FIN;
              r_done  <= 1'b1;
            end
`endif
          end
        end
        LOAD_W: begin
          if (w_xfer) begin
            r_we    <= 1'b1;
            r_addr  <= r_ptr;
            r_wdata <= i_in_data;
            r_ptr   <= r_ptr + 16'd1;
            r_wleft <= r_wleft - 16'd1;
            if (r_wleft == 16'd1) begin
`ifdef WEIGHT_LOADER_BIAS_EN
              r_state <= LOAD_B;
`else
              r_state    <= FIN;
              r_in_ready <= 1'b0;
              r_done     <= 1'b1;
`endif
            end
          end
        end
`ifdef WEIGHT_LOADER_BIAS_EN
        LOAD_B: begin
          if (w_xfer) begin
            r_we    <= 1'b1;
            r_addr  <= r_bias_base + 16'(w_idx);
            r_wdata <= i_in_data;
            r_rem   <= w_rem_nx;
            if (w_rem_nx == '0) begin
              r_state    <= FIN;
              r_in_ready <= 1'b0;
              r_done     <= 1'b1;
            end
          end
        end
`endif
        FIN: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_mem_we    = r_we;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;

endmodule

// File: tb/tb_weight_loader.sv
// Randomized directed bench for weight_loader against an address-list model.
module tb_weight_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [15:0] i_start_addr;
  logic [7:0]  i_kernel_size;
  logic [3:0]  i_active_units;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [15:0] i_in_data;
  logic        o_mem_we;
  logic [15:0] o_mem_addr;
  logic [15:0] o_mem_wdata;
  logic        o_busy;
  logic        o_done;

  int checks = 0;
  int errors = 0;

  logic [31:0] obs[$];
  int          done_cnt;
  logic        done_we;
  int          done_widx;
  int          rdy_bad = 0;

  always #5 clk = ~clk;

  weight_loader #(.N_UNITS(4), .DATA_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (i_start),
    .i_start_addr   (i_start_addr),
    .i_kernel_size  (i_kernel_size),
    .i_active_units (i_active_units),
    .i_in_valid     (i_in_valid),
    .o_in_ready     (o_in_ready),
    .i_in_data      (i_in_data),
    .o_mem_we       (o_mem_we),
    .o_mem_addr     (o_mem_addr),
    .o_mem_wdata    (o_mem_wdata),
    .o_busy         (o_busy),
    .o_done         (o_done)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (o_mem_we) obs.push_back({o_mem_addr, o_mem_wdata});
      if (o_done) begin
        done_cnt++;
        done_we   = o_mem_we;
        done_widx = obs.size();
      end
      if (o_in_ready && !o_busy) rdy_bad++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Expected address list: compacted kernels, then biases at physical index.
  task automatic run(input logic [15:0] sa, input logic [7:0] ks,
                     input logic [3:0] m, input int gap,
                     input bit restart);
    logic [15:0] ea[$];
    logic [15:0] dq[$];
    int cnt, nw, k, cyc;
    bit xfer;
    logic [15:0] bb;
    cnt = $countones(m);
    nw  = cnt * int'(ks);
    bb  = sa + 16'(nw);
    for (int j = 0; j < nw; j++) ea.push_back(sa + 16'(j));
`ifdef WEIGHT_LOADER_BIAS_EN
    for (int i = 0; i < 4; i++) if (m[i]) ea.push_back(bb + 16'(i));
`endif
    foreach (ea[j]) dq.push_back(16'($urandom));
    obs.delete();
    done_cnt = 0;
    i_start_addr   = sa;
    i_kernel_size  = ks;
    i_active_units = m;
    i_start        = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    k = 0;
    cyc = 0;
    while (k < dq.size() && cyc < 2000) begin
      i_start    = 1'b0;
      i_in_valid = ($urandom_range(0, 99) >= gap);
      i_in_data  = dq[k];
      if (restart && cyc == 2) begin
        i_start        = 1'b1;
        i_start_addr   = 16'h5555;
        i_kernel_size  = 8'd1;
        i_active_units = 4'b0001;
      end
      xfer = i_in_valid && o_in_ready;
      @(negedge clk);
      if (xfer) k++;
      cyc++;
    end
    i_start    = 1'b0;
    i_in_valid = 1'b0;
    chk("stream_budget", 32'(cyc < 2000), 32'd1);
    cyc = 0;
    while (done_cnt == 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("write_count", 32'(obs.size()), 32'(ea.size()));
    for (int j = 0; j < ea.size() && j < obs.size(); j++) begin
      chk($sformatf("addr[%0d]", j), 32'(obs[j][31:16]), 32'(ea[j]));
      chk($sformatf("data[%0d]", j), 32'(obs[j][15:0]), 32'(dq[j]));
    end
    if (ea.size() > 0) begin
      chk("done_with_last_we", 32'(done_we), 32'd1);
      chk("done_write_index", 32'(done_widx), 32'(ea.size()));
    end else begin
      chk("done_without_we", 32'(done_we), 32'd0);
    end
    chk("idle_after", {o_busy, o_in_ready, o_done}, 32'd0);
  endtask

  initial begin
    int k;
    rst            = 1'b1;
    i_start        = 1'b0;
    i_start_addr   = '0;
    i_kernel_size  = '0;
    i_active_units = '0;
    i_in_valid     = 1'b0;
    i_in_data      = '0;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {o_in_ready, o_mem_we, o_busy, o_done}, 32'd0);
    chk("rst_addr", 32'(o_mem_addr), 32'd0);
    chk("rst_wdata", 32'(o_mem_wdata), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run(16'h0100, 8'd3, 4'b1111, 0, 1'b0);
    run(16'h0200, 8'd2, 4'b1010, 0, 1'b0);
    repeat (3) run(16'h0100, 8'd3, 4'b1111, 50, 1'b0);
    run(16'h0300, 8'd4, 4'b0000, 0, 1'b0);
    run(16'h0400, 8'd0, 4'b0011, 0, 1'b0);
    run(16'hFFFE, 8'd4, 4'b0001, 30, 1'b0);
    run(16'h0100, 8'd3, 4'b1111, 20, 1'b1);
    repeat (6)
      run(16'($urandom), 8'($urandom_range(0, 5)),
          4'($urandom), $urandom_range(0, 60), 1'b0);

    obs.delete();
    done_cnt       = 0;
    i_start_addr   = 16'h0100;
    i_kernel_size  = 8'd3;
    i_active_units = 4'b1111;
    i_start        = 1'b1;
    @(negedge clk);
    i_start    = 1'b0;
    i_in_valid = 1'b1;
    k = 0;
    for (int c = 0; c < 20 && k < 5; c++) begin
      i_in_data = 16'(k + 16'hA0);
      if (o_in_ready) k++;
      @(negedge clk);
    end
    i_in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("abort_ctrl", {o_in_ready, o_mem_we, o_busy, o_done}, 32'd0);
    chk("abort_addr", 32'(o_mem_addr), 32'd0);
    chk("abort_wdata", 32'(o_mem_wdata), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    chk("abort_writes", 32'(obs.size()), 32'd5);
    chk("ready_idle_violations", 32'(rdy_bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
